switch_conditioner: RTL and testbench

//  Front end for one Go Board push-button, feeding the 7-seg counter logic. Synchronises and

---
 rtl/go_board_pkg.sv | 20 ++
 rtl/debounce_filter.sv | 51 +++++
 rtl/switch_conditioner.sv | 116 +++++++++++
 tb/tb_switch_conditioner.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/go_board_pkg.sv
// Shared definitions for Go Board push-button front ends: hold FSM encoding and
// default timing constants for a 25 MHz board clock.
package go_board_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StRepeat = 2'd2,
        StHeld   = 2'd3
    } hold_state_e;

    localparam int unsigned DebounceLimitDefault = 250000;    // 10 ms
    localparam int unsigned RepeatDelayDefault   = 12500000;  // 500 ms
    localparam int unsigned RepeatRateDefault    = 2500000;   // 100 ms

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter: the debounced level only
// follows the synchronised input after it has held a new value for DEBOUNCE_LIMIT cycles.
module debounce_filter
    import go_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DebounceLimitDefault
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

    logic            sync_meta_q;
    logic            sync_q;
    logic            switch_q, switch_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        switch_d = switch_q;
        if (sync_q == switch_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            switch_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            switch_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_meta_q <= i_Switch;
            sync_q      <= sync_meta_q;
            switch_q    <= switch_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_Switch = switch_q;

endmodule

// File: rtl/switch_conditioner.sv
// Push-button front end: debounced level plus registered one-cycle press, release and
// long-hold pulses, with an optional auto-repeat press train while the button is held.
module switch_conditioner
    import go_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DebounceLimitDefault,
    parameter int unsigned REPEAT_DELAY   = RepeatDelayDefault,
    parameter int unsigned REPEAT_RATE    = RepeatRateDefault
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    input  logic i_Repeat_En,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long
);

    localparam int unsigned      HoldW    = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [HoldW-1:0] DelayMax = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] RateMax  = HoldW'(REPEAT_RATE - 1);

    hold_state_e      state_q, state_d;
    logic [HoldW-1:0] hcnt_q, hcnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch)
    );

    // Release is tested first in every held state so it beats any same-cycle terminal count.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (o_Switch) begin
                    press_d = 1'b1;
                    hcnt_d  = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!o_Switch) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (hcnt_q == DelayMax) begin
                    long_d = 1'b1;
                    hcnt_d = '0;
                    if (i_Repeat_En) begin
                        press_d = 1'b1;
                        state_d = StRepeat;
                    end else begin
                        state_d = StHeld;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StRepeat: begin
                if (!o_Switch) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (hcnt_q == RateMax) begin
                    hcnt_d = '0;
                    if (i_Repeat_En) begin
                        press_d = 1'b1;
                    end else begin
                        state_d = StHeld;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!o_Switch) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= StIdle;
            hcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Long    = long_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scenario bench for switch_conditioner: expected pulses (cycle, kind) are queued as stimulus
// is applied and matched in order against the pulses the DUT emits.
module tb_switch_conditioner;

    localparam int unsigned DebLimit = 4;
    localparam int unsigned RepDelay = 20;
    localparam int unsigned RepRate  = 5;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  ev;   // {press, release, long}
    } ev_t;

    localparam logic [2:0] EvPress   = 3'b100;
    localparam logic [2:0] EvRelease = 3'b010;
    localparam logic [2:0] EvPrLong  = 3'b101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw = 1'b0;
    logic rep_en = 1'b0;
    logic o_sw, o_press, o_release, o_long;

    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    switch_conditioner #(
        .DEBOUNCE_LIMIT(DebLimit),
        .REPEAT_DELAY  (RepDelay),
        .REPEAT_RATE   (RepRate)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_Switch   (sw),
        .i_Repeat_En(rep_en),
        .o_Switch   (o_sw),
        .o_Press    (o_press),
        .o_Release  (o_release),
        .o_Long     (o_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_press || o_release || o_long)
            obs_q.push_back(ev_t'({cyc, o_press, o_release, o_long}));
    end

    function automatic ev_t mk(input int unsigned c, input logic [2:0] e);
        return '{cyc: c, ev: e};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sw = 1'b0;
        rep_en = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int unsigned t0;
        ev_t e, o;
        @(negedge clk);
        sw = 1'b1;
        rst_n = 1'b0;
        step(3);
        checks++;
        if (o_sw !== 1'b0) begin errors++; $display("FAIL reset_switch: got %b want 0", o_sw); end
        checks++;
        if (o_press !== 1'b0) begin errors++; $display("FAIL reset_press: got %b want 0", o_press); end
        checks++;
        if (o_release !== 1'b0) begin errors++; $display("FAIL reset_release: got %b want 0", o_release); end
        checks++;
        if (o_long !== 1'b0) begin errors++; $display("FAIL reset_long: got %b want 0", o_long); end
        obs_q.delete();
        t0 = cyc;
        rst_n = 1'b1;
        exp_q.push_back(mk(t0 + 7, EvPress));
        step(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL reset_held missing: got none, want ev=%b at cyc %0d", e.ev, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_held event: got ev=%b at cyc %0d, want ev=%b at cyc %0d", o.ev, o.cyc, e.ev, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL reset_held extra: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_single();
        int unsigned t0, t1;
        ev_t e, o;
        do_reset();
        t0 = cyc;
        sw = 1'b1;
        exp_q.push_back(mk(t0 + 7, EvPress));
        exp_q.push_back(mk(t0 + 27, 3'b001));
        step(5);
        checks++;
        if (o_sw !== 1'b0) begin errors++; $display("FAIL single_early_switch: got %b want 0", o_sw); end
        step(1);
        checks++;
        if (o_sw !== 1'b1) begin errors++; $display("FAIL single_switch: got %b want 1", o_sw); end
        step(54);
        t1 = cyc;
        sw = 1'b0;
        exp_q.push_back(mk(t1 + 7, EvRelease));
        step(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL single missing: got none, want ev=%b at cyc %0d", e.ev, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL single event: got ev=%b at cyc %0d, want ev=%b at cyc %0d", o.ev, o.cyc, e.ev, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL single extra: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_bounce();
        int unsigned t0;
        logic [9:0] pat;
        ev_t e, o;
        do_reset();
        pat = 10'b0110111001;  // applied LSB first: 1,0,0,1,1,1,0,1,1,0
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            sw = pat[i];
            @(negedge clk);
            checks++;
            if (o_sw !== 1'b0) begin errors++; $display("FAIL bounce_glitch[%0d]: got %b want 0", i, o_sw); end
        end
        sw = 1'b1;
        exp_q.push_back(mk(t0 + 17, EvPress));
        exp_q.push_back(mk(t0 + 27, EvRelease));
        step(5);
        checks++;
        if (o_sw !== 1'b0) begin errors++; $display("FAIL bounce_early_switch: got %b want 0", o_sw); end
        step(1);
        checks++;
        if (o_sw !== 1'b1) begin errors++; $display("FAIL bounce_switch: got %b want 1", o_sw); end
        step(4);
        sw = 1'b0;
        step(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL bounce missing: got none, want ev=%b at cyc %0d", e.ev, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL bounce event: got ev=%b at cyc %0d, want ev=%b at cyc %0d", o.ev, o.cyc, e.ev, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL bounce extra: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_repeat(input int unsigned rel_at, input int unsigned rel_pulse);
        int unsigned t0;
        ev_t e, o;
        do_reset();
        t0 = cyc;
        rep_en = 1'b1;
        sw = 1'b1;
        exp_q.push_back(mk(t0 + 7, EvPress));
        exp_q.push_back(mk(t0 + 27, EvPrLong));
        for (int k = 32; k <= 62; k += 5) exp_q.push_back(mk(t0 + k, EvPress));
        exp_q.push_back(mk(t0 + rel_pulse, EvRelease));
        step(rel_at);
        sw = 1'b0;
        step(20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL repeat_%0d missing: got none, want ev=%b at cyc %0d", rel_at, e.ev, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL repeat_%0d event: got ev=%b at cyc %0d, want ev=%b at cyc %0d", rel_at, o.ev, o.cyc, e.ev, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL repeat_%0d extra: got %0d pulses want 0", rel_at, obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int unsigned t0;
        ev_t e, o;
        do_reset();
        t0 = cyc;
        rep_en = 1'b1;
        sw = 1'b1;
        exp_q.push_back(mk(t0 + 7, EvPress));
        exp_q.push_back(mk(t0 + 27, EvPrLong));
        exp_q.push_back(mk(t0 + 32, EvPress));
        exp_q.push_back(mk(t0 + 43, EvPress));
        exp_q.push_back(mk(t0 + 57, EvRelease));
        step(35);
        checks++;
        if (o_sw !== 1'b1) begin errors++; $display("FAIL midrst_pre_switch: got %b want 1", o_sw); end
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({o_sw, o_press, o_release, o_long} !== 4'b0000) begin
            errors++; $display("FAIL midrst_outputs: got %b want 0000", {o_sw, o_press, o_release, o_long});
        end
        rst_n = 1'b1;
        step(14);
        sw = 1'b0;
        step(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL midrst missing: got none, want ev=%b at cyc %0d", e.ev, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL midrst event: got ev=%b at cyc %0d, want ev=%b at cyc %0d", o.ev, o.cyc, e.ev, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midrst extra: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_repeat_off();
        int unsigned t0;
        ev_t e, o;
        do_reset();
        t0 = cyc;
        rep_en = 1'b1;
        sw = 1'b1;
        exp_q.push_back(mk(t0 + 7, EvPress));
        exp_q.push_back(mk(t0 + 27, EvPrLong));
        exp_q.push_back(mk(t0 + 32, EvPress));
        exp_q.push_back(mk(t0 + 37, EvPress));
        exp_q.push_back(mk(t0 + 57, EvRelease));
        step(38);
        rep_en = 1'b0;
        step(12);
        sw = 1'b0;
        step(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL repoff missing: got none, want ev=%b at cyc %0d", e.ev, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL repoff event: got ev=%b at cyc %0d, want ev=%b at cyc %0d", o.ev, o.cyc, e.ev, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL repoff extra: got %0d pulses want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bounce();
        test_repeat(58, 65);   // release lands between repeat counts
        test_repeat(60, 67);   // debounced drop meets a repeat terminal count
        test_reset_mid();
        test_repeat_off();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
